instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Instruction-fetch stage of the single-cycle MIPS core: owns the PC, fetches one
//   32-bit word per instruction over a req/ack instruction-memory port, holds it in an
//   instruction register, and drives opcode [31:26] to the control unit and funct [5:0]
//   to ALU control. Computes the next PC from the branch decision returned by the datapath.
// PARAMETERS
//   ADDR_W    32  PC / instruction-memory address width (>= 8)
//   RESET_PC  0   PC value after reset (multiple of 4)
//   CNT_W     16  width of retired-instruction counter
// PORTS
//   clk          in   1       system clock, all state on rising edge
//   rst          in   1       synchronous reset, active-high
//   imem_req     out  1       fetch request
//   imem_addr    out  ADDR_W  fetch address (= pc)
//   imem_rdata   in   32      instruction word, valid when imem_ack=1
//   imem_ack     in   1       memory completion, one cycle per request
//   exec_done    in   1       datapath finished current instruction
//   branch_cond  in   1       SaltoCond from control unit
//   alu_zero     in   1       ALU zero flag
//   instr        out  32      instruction register
//   opcode       out  6       instr[31:26], to control unit
//   funct        out  6       instr[5:0], to ALU control
//   instr_valid  out  1       instr is stable and executing
//   pc           out  ADDR_W  address of current instruction
//   pc_plus4     out  ADDR_W  pc + 4
//   retired      out  CNT_W   instructions completed since reset
// BEHAVIOUR
//   - Clock/reset: one clock; reset is synchronous and active-high on clk/rst.
//   - Reset values: pc=RESET_PC, instr=0 (opcode 0 = R-type default), instr_valid=0,
//     retired=0, state=FETCH; imem_req=0 whenever rst=1.
//   - FSM: FETCH -> DECODE -> EXEC -> FETCH.
//     FETCH : imem_req=1, imem_addr=pc; held until imem_ack. Edge with ack: instr<=imem_rdata,
//             -> DECODE. Ack in same cycle req first rises is legal (zero-wait memory).
//     DECODE: exactly 1 cycle; instr_valid=1; gives registered control unit one edge to
//             latch opcode. exec_done ignored here. -> EXEC.
//     EXEC  : instr_valid=1; wait for exec_done. Edge with exec_done: pc<=next_pc,
//             retired<=retired+1, -> FETCH (instr_valid=0 from next cycle).
//   - Minimum latency per instruction: 3 cycles (ack on first FETCH cycle, exec_done on
//     first EXEC cycle).
//   - next_pc = (branch_cond & alu_zero) ? pc+4 + (sext(instr[15:0])<<2) : pc+4,
//     sampled on exec_done edge; arithmetic modulo 2^ADDR_W (wraps, no flag).
//   - pc[1:0] forced 0 at all times; imem_addr[1:0]=0.
//   - instr, opcode, funct constant from DECODE entry until next ack.
//   - imem_ack outside FETCH ignored; memory must not ack without req.
//   - retired wraps 2^CNT_W-1 -> 0.
//   - Reset mid-operation: pending fetch abandoned, no instr update, state FETCH at
//     RESET_PC; a stale ack arriving in the reset cycle is ignored.
//   - branch_cond/alu_zero sampled only on the exec_done edge; X elsewhere is tolerated.
// CONFIGURATION
//   JUMP_EN defined: opcode 6'b000010 (j) gives next_pc = {pc_plus4[ADDR_W-1:28],
//     instr[25:0],2'b00} (zero-extended high bits when ADDR_W<32: truncate), overriding
//     branch. Undefined: j treated as ordinary instruction, next_pc per branch rule.
// TESTING
//   1 Reset: rst=1 two cycles, RESET_PC=0x40 -> pc=0x40, instr=0, instr_valid=0,
//     imem_req=0; first cycle after release imem_req=1, imem_addr=0x40.
//   2 Sequential: zero-wait ack, exec_done on first EXEC cycle, 4 instrs -> pc 0,4,8,C,
//     3 cycles each, retired=4, opcode/funct match words fetched.
//   3 Wait states: ack delayed 5 cycles -> imem_req/imem_addr held stable, instr
//     unchanged until ack edge, instr_valid=0 throughout FETCH.
//   4 Branch: pc=0x10, instr imm=0xFFFC, branch_cond=1, alu_zero=1 -> next pc=0x04;
//     alu_zero=0 -> 0x14; imm=0x7FFF from pc=0xFFFFFFF0 -> wraps to 0x0001FFF0.
//   5 Reset mid-fetch: rst during FETCH with ack same cycle -> instr stays 0, pc=RESET_PC,
//     retired=0.
//   6 JUMP_EN: j 0x0000100 at pc=0x20 -> next pc=0x400; without macro -> 0x24.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage of the single-cycle MIPS core.
// Owns the PC, fetches one word per instruction over a req/ack port, holds it
// in the instruction register and computes the next PC from the branch result.
// Optional feature: define JUMP_EN to decode 'j' (opcode 6'b000010) here.
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  input  logic              exec_done,
  input  logic              branch_cond,
  input  logic              alu_zero,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

  localparam logic [5:0] OP_J = 6'b000010;

  state_t            state;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jump_pc;
  logic              is_jump;
  logic [ADDR_W-1:0] next_pc;

  // Field decode and PC arithmetic; addresses wrap modulo 2^ADDR_W.
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign pc_plus4  = pc + ADDR_W'(4);
  assign imem_addr = pc;
  // The request is gated by rst so a pending fetch disappears in the reset cycle.
  assign imem_req  = (state == FETCH) && !rst;

  // Sign-extended word offset; the cast of a signed value extends or truncates to ADDR_W.
  assign br_off = ADDR_W'($signed({instr[15:0], 2'b00}));

`ifdef JUMP_EN
  assign is_jump = (instr[31:26] == OP_J);
  generate
    if (ADDR_W > 28) begin : g_jump_wide
      assign jump_pc = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
    end else begin : g_jump_narrow
      assign jump_pc = ADDR_W'({instr[25:0], 2'b00});
    end
  endgenerate
`else
  assign is_jump = 1'b0;
  assign jump_pc = pc_plus4;
`endif

  // Next-PC selection: jump overrides a taken branch, otherwise fall through.
  always_comb begin
    // NOTE: assign a default first so every path drives next_pc and no latch is inferred.
    next_pc = pc_plus4;
    if (is_jump) begin
      next_pc = jump_pc;
    end else if (branch_cond && alu_zero) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  // Fetch/decode/execute sequencer with registered PC, IR, valid flag and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the instruction register is reset on purpose so opcode reads 0 (R-type) until the first fetch.
      state       <= FETCH;
      pc          <= {RESET_PC[ADDR_W-1:2], 2'b00};
      instr       <= '0;
      instr_valid <= 1'b0;
      retired     <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= DECODE;
          end
        end
        DECODE: begin
          state <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            pc          <= {next_pc[ADDR_W-1:2], 2'b00};
            retired     <= retired + CNT_W'(1);
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch. Fetched words and their
// expected PC are queued when the memory acks and compared on DECODE entry.
module tb_instr_fetch;

  localparam int          ADDR_W   = 32;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h40;

  logic              clk;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ack;
  logic              exec_done;
  logic              branch_cond;
  logic              alu_zero;
  logic [31:0]       instr;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [CNT_W-1:0]  retired;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] mpc;
  logic [3:0]  mret;

  instr_fetch #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .exec_done  (exec_done),
    .branch_cond(branch_cond),
    .alu_zero   (alu_zero),
    .instr      (instr),
    .opcode     (opcode),
    .funct      (funct),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                             input logic bc, input logic az);
    logic [31:0] p4;
    p4 = cur + 32'd4;
`ifdef JUMP_EN
    if (w[31:26] == 6'b000010) return {p4[31:28], w[25:0], 2'b00};
`endif
    if (bc && az) return p4 + {{14{w[15]}}, w[15:0], 2'b00};
    return p4;
  endfunction

  // One complete instruction; entered and left at a FETCH cycle.
  task automatic do_instr(input logic [31:0] word, input int ack_wait, input int exec_wait,
                          input logic bc, input logic az, input logic done_in_decode);
    logic [31:0] prev;
    logic [31:0] nxt;
    exp_t        e;
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, mpc);
    check("fetch_valid", 32'(instr_valid), 32'd0);
    prev = instr;
    for (int i = 0; i < ack_wait; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      step();
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, mpc);
      check("wait_instr", instr, prev);
      check("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    sb.push_back('{word: word, addr: mpc});
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    // DECODE: compare against the scoreboard entry; exec_done must be ignored here.
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("dec_instr", instr, e.word);
      check("dec_opcode", 32'(opcode), 32'(e.word[31:26]));
      check("dec_funct", 32'(funct), 32'(e.word[5:0]));
      check("dec_pc", pc, e.addr);
    end
    check("dec_valid", 32'(instr_valid), 32'd1);
    check("dec_pc4", pc_plus4, mpc + 32'd4);
    check("dec_req", 32'(imem_req), 32'd0);
    exec_done   = done_in_decode;
    branch_cond = 1'($urandom);
    alu_zero    = 1'($urandom);
    step();
    exec_done = 1'b0;
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_pc", pc, mpc);
    for (int i = 0; i < exec_wait; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = ~word;
      step();
      check("exec_wait_valid", 32'(instr_valid), 32'd1);
      check("exec_wait_instr", instr, word);
    end
    imem_ack    = 1'b0;
    exec_done   = 1'b1;
    branch_cond = bc;
    alu_zero    = az;
    nxt         = model_next(mpc, word, bc, az);
    step();
    exec_done   = 1'b0;
    branch_cond = 1'b0;
    alu_zero    = 1'b0;
    mpc         = nxt;
    mret        = mret + 4'd1;
    check("ret_pc", pc, mpc);
    check("ret_count", 32'(retired), 32'(mret));
    check("ret_valid", 32'(instr_valid), 32'd0);
    check("ret_instr", instr, word);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; branch_cond = 1'b0; alu_zero = 1'b0;
    mpc = RESET_PC; mret = '0;

    // Reset held for two cycles.
    step();
    check("rst_req0", 32'(imem_req), 32'd0);
    step();
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_ret", 32'(retired), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_req", 32'(imem_req), 32'd1);
    check("rel_addr", imem_addr, RESET_PC);

    // Sequential, minimum latency.
    do_instr(32'h0122_4020, 0, 0, 1'b1, 1'b0, 1'b0);
    do_instr(32'h8C43_0008, 0, 0, 1'b0, 1'b1, 1'b0);
    do_instr(32'h0085_302A, 0, 0, 1'b0, 1'b0, 1'b1);
    do_instr(32'hAC45_0010, 0, 0, 1'b0, 1'b0, 1'b0);
    check("seq_pc", pc, 32'h50);
    check("seq_ret", 32'(retired), 32'd4);

    // Five wait states on the fetch.
    do_instr(32'h00A6_3822, 5, 2, 1'b0, 1'b0, 1'b0);

    // Branches: 0x54 -> 0x10 -> 0x04 -> 0x10 -> 0x14 (not taken) -> 0xFFFFFFF0 -> 0x1FFF0 -> 0x20.
    do_instr(32'h1000_FFEE, 0, 0, 1'b1, 1'b1, 1'b0);
    check("br_to_10", pc, 32'h10);
    do_instr(32'h1000_FFFC, 0, 1, 1'b1, 1'b1, 1'b0);
    check("br_back", pc, 32'h04);
    do_instr(32'h1000_0002, 1, 0, 1'b1, 1'b1, 1'b0);
    do_instr(32'h1000_FFFC, 0, 0, 1'b1, 1'b0, 1'b0);
    check("br_nz", pc, 32'h14);
    do_instr(32'h1000_FFF6, 0, 0, 1'b1, 1'b1, 1'b0);
    check("br_neg", pc, 32'hFFFF_FFF0);
    do_instr(32'h1000_7FFF, 0, 0, 1'b1, 1'b1, 1'b0);
    check("br_wrap", pc, 32'h0001_FFF0);
    do_instr(32'h1000_800B, 0, 0, 1'b1, 1'b1, 1'b0);
    check("br_to_20", pc, 32'h20);

    // j 0x100 at 0x20 with a taken branch condition present.
    do_instr({6'b000010, 26'h0000100}, 0, 0, 1'b1, 1'b1, 1'b0);
`ifdef JUMP_EN
    check("jump", pc, 32'h400);
`else
    check("jump", pc, 32'h424);
`endif

    // Random non-branching traffic; retired counter wraps past 15.
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      do_instr(w, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               1'b0, 1'($urandom), 1'($urandom));
    end

    // Reset during FETCH with a stale ack in the same cycle.
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check("mid_instr", instr, 32'd0);
    check("mid_pc", pc, RESET_PC);
    check("mid_ret", 32'(retired), 32'd0);
    check("mid_valid", 32'(instr_valid), 32'd0);
    check("mid_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    mpc = RESET_PC;
    mret = '0;
    #1;
    check("mid_rel_req", 32'(imem_req), 32'd1);
    do_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0);
    check("mid_resume", pc, 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
